// File: rtl/multicycle_control.sv
// Multicycle RV32 subset control unit: a state-register FSM that sequences the
// shared-ULA datapath. It also counts retired instructions and flags unsupported encodings.
module multicycle_control #(
    parameter int ULACTRL_W     = 3,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           OP,
    input  logic [2:0]           Funct3,
    input  logic [6:0]           Funct7,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ULASrcA,
    output logic [1:0]           ULASrcB,
    output logic [1:0]           ImmSrc,
    output logic [ULACTRL_W-1:0] ULAControl,
    output logic                 InstrDone,
    output logic                 IllegalOp,
    output logic [CNT_W-1:0]     Retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        JALR_A   = 4'd11,
        JALR_B   = 4'd12
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_XOR = 3'b100;
    localparam logic [2:0] ULA_SLT = 3'b101;
    localparam logic [2:0] ULA_SRL = 3'b110;

    state_t           state_reg;
    state_t           state_next;
    state_t           dec_state;
    logic [2:0]       dec_op;
    logic             dec_store;
    logic             dec_illegal;
    logic [2:0]       alu_op_reg;
    logic             store_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] imm_src;
    logic [2:0] ula_op;
    logic       instr_done;
    logic       illegal_op;

    assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

    // Instruction decode: dispatch state plus the ULA op / store flag that later
    // states need. Anything not matched falls back to FETCH and is flagged illegal.
    always_comb begin
        dec_state = FETCH;
        dec_op    = ULA_ADD;
        dec_store = 1'b0;
        case (OP)
            OP_R: begin
                dec_state = EXECR;
                case ({Funct7, Funct3})
                    {7'b0000000, 3'b000}: dec_op = ULA_ADD;
                    {7'b0100000, 3'b000}: dec_op = ULA_SUB;
                    {7'b0000000, 3'b111}: dec_op = ULA_AND;
                    {7'b0000000, 3'b110}: dec_op = ULA_OR;
                    {7'b0000000, 3'b100}: dec_op = ULA_XOR;
                    {7'b0000000, 3'b010}: dec_op = ULA_SLT;
                    {7'b0000000, 3'b101}: dec_op = ULA_SRL;
                    default:              dec_state = FETCH;
                endcase
            end
            OP_I: begin
                dec_state = EXECI;
                case (Funct3)
                    3'b000:  dec_op = ULA_ADD;
                    3'b111:  dec_op = ULA_AND;
                    3'b110:  dec_op = ULA_OR;
                    default: dec_state = FETCH;
                endcase
            end
            OP_LW: begin
                if (Funct3 == 3'b010) begin
                    dec_state = MEMADR;
                end
            end
            OP_SW: begin
                if (Funct3 == 3'b010) begin
                    dec_state = MEMADR;
                    dec_store = 1'b1;
                end
            end
            OP_BEQ: begin
                if (Funct3 == 3'b000) begin
                    dec_state = BEQ;
                end
            end
            OP_JAL: begin
                dec_state = JAL;
            end
            OP_JALR: begin
                if (Funct3 == 3'b000) begin
                    dec_state = JALR_A;
                end
            end
            default: begin
                dec_state = FETCH;
            end
        endcase
    end

    assign dec_illegal = (dec_state == FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            alu_op_reg  <= ULA_ADD;
            store_reg   <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                alu_op_reg <= dec_op;
                store_reg  <= dec_store;
            end
            if (instr_done) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        ula_src_a  = 2'b00;
        ula_src_b  = 2'b00;
        imm_src    = 2'b00;
        ula_op     = ULA_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_reg)
            FETCH: begin
                ula_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Target precompute: jal needs the J immediate, branches the B immediate.
                ula_src_a  = 2'b01;
                ula_src_b  = 2'b01;
                imm_src    = (OP == OP_JAL) ? 2'b11 : 2'b10;
                illegal_op = dec_illegal;
                state_next = dec_state;
            end
            MEMADR: begin
                ula_src_a  = 2'b10;
                ula_src_b  = 2'b01;
                imm_src    = store_reg ? 2'b01 : 2'b00;
                state_next = store_reg ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                state_next = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                state_next = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ula_src_a  = 2'b10;
                ula_op     = alu_op_reg;
                state_next = ALUWB;
            end
            EXECI: begin
                ula_src_a  = 2'b10;
                ula_src_b  = 2'b01;
                ula_op     = alu_op_reg;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ula_src_a  = 2'b10;
                ula_op     = ULA_SUB;
                imm_src    = 2'b10;
                pc_write   = Zero;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                ula_src_a  = 2'b01;
                ula_src_b  = 2'b10;
                imm_src    = 2'b11;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            JALR_A: begin
                ula_src_a  = 2'b10;
                ula_src_b  = 2'b01;
                state_next = JALR_B;
            end
            JALR_B: begin
                ula_src_a  = 2'b01;
                ula_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Side effects are suppressed for the whole reset cycle, even mid-instruction.
    assign PCWrite   = pc_write   & ~reset;
    assign MemWrite  = mem_write  & ~reset;
    assign IRWrite   = ir_write   & ~reset;
    assign RegWrite  = reg_write  & ~reset;
    assign InstrDone = instr_done & ~reset;
    assign IllegalOp = illegal_op & ~reset;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ULASrcA   = ula_src_a;
    assign ULASrcB   = ula_src_b;
    assign ImmSrc    = imm_src;
    assign Retired   = retired_reg;

    assign ULAControl[2:0] = ula_op;
    genvar gi;
    generate
        for (gi = 3; gi < ULACTRL_W; gi++) begin : g_ula_pad
            assign ULAControl[gi] = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction aggregate model of
// cycle count, enable pulses and retirement, plus reset scenarios.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  OP;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ULASrcA, ULASrcB, ImmSrc;
    logic [2:0]  ULAControl;
    logic        InstrDone, IllegalOp;
    logic [31:0] Retired;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP(OP), .Funct3(Funct3), .Funct7(Funct7),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
        .ImmSrc(ImmSrc), .ULAControl(ULAControl), .InstrDone(InstrDone),
        .IllegalOp(IllegalOp), .Retired(Retired)
    );

    always #5 clk = ~clk;

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4,
                   C_JAL = 5, C_JALR = 6, C_ILL = 7;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] retired_model = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sets the instruction fields for a class/variant and returns the ULA op it implies.
    task automatic set_instr(input int cls, input int v, output logic [2:0] exp_ula);
        Funct7  = 7'($urandom);
        Funct3  = 3'($urandom);
        exp_ula = 3'd0;
        case (cls)
            C_R: begin
                OP = 7'b0110011;
                case (v)
                    0: begin Funct3 = 3'b000; Funct7 = 7'h00; exp_ula = 3'd0; end
                    1: begin Funct3 = 3'b000; Funct7 = 7'h20; exp_ula = 3'd1; end
                    2: begin Funct3 = 3'b111; Funct7 = 7'h00; exp_ula = 3'd2; end
                    3: begin Funct3 = 3'b110; Funct7 = 7'h00; exp_ula = 3'd3; end
                    4: begin Funct3 = 3'b100; Funct7 = 7'h00; exp_ula = 3'd4; end
                    5: begin Funct3 = 3'b010; Funct7 = 7'h00; exp_ula = 3'd5; end
                    default: begin Funct3 = 3'b101; Funct7 = 7'h00; exp_ula = 3'd6; end
                endcase
            end
            C_I: begin
                OP = 7'b0010011;
                case (v)
                    0: begin Funct3 = 3'b000; exp_ula = 3'd0; end
                    1: begin Funct3 = 3'b111; exp_ula = 3'd2; end
                    default: begin Funct3 = 3'b110; exp_ula = 3'd3; end
                endcase
            end
            C_LW:   begin OP = 7'b0000011; Funct3 = 3'b010; end
            C_SW:   begin OP = 7'b0100011; Funct3 = 3'b010; end
            C_BEQ:  begin OP = 7'b1100011; Funct3 = 3'b000; exp_ula = 3'd1; end
            C_JAL:  begin OP = 7'b1101111; end
            C_JALR: begin OP = 7'b1100111; Funct3 = 3'b000; end
            default: begin
                case (v)
                    0: OP = 7'b1111111;
                    1: begin OP = 7'b0110011; Funct3 = 3'b001; Funct7 = 7'h00; end
                    2: begin OP = 7'b0110011; Funct3 = 3'b101; Funct7 = 7'h20; end
                    3: begin OP = 7'b0010011; Funct3 = 3'b100; end
                    4: begin OP = 7'b0000011; Funct3 = 3'b000; end
                    default: begin OP = 7'b1100011; Funct3 = 3'b001; end
                endcase
            end
        endcase
    endtask

    // One instruction: fs stall cycles in fetch, ms stall cycles in the memory wait.
    task automatic run_instr(input int cls, input int v, input int fs, input int ms,
                             input logic zero_v, input string name);
        logic [2:0] exp_ula;
        logic       plan[$];
        int steps, wait_at, n;
        int pcw = 0, rw = 0, rw_last = 0, mw = 0, irw = 0, irw_at = -1;
        int done = 0, done_at = -1, ill = 0, ill_at = -1, adr = 0;
        logic [2:0] ula_exec = 3'd7;
        logic [1:0] rsrc_last = 2'b11;
        bit writer, is_mem;

        set_instr(cls, v, exp_ula);
        case (cls)
            C_R, C_I: begin steps = 3; wait_at = -1; end
            C_LW:     begin steps = 4; wait_at = 3;  end
            C_SW:     begin steps = 3; wait_at = 3;  end
            C_BEQ:    begin steps = 2; wait_at = -1; end
            C_JAL:    begin steps = 3; wait_at = -1; end
            C_JALR:   begin steps = 4; wait_at = -1; end
            default:  begin steps = 1; wait_at = -1; end
        endcase
        for (int i = 0; i < fs; i++) plan.push_back(1'b0);
        plan.push_back(1'b1);
        for (int s = 1; s <= steps; s++) begin
            if (s == wait_at) begin
                for (int i = 0; i < ms; i++) plan.push_back(1'b0);
                plan.push_back(1'b1);
            end else begin
                plan.push_back(1'($urandom));
            end
        end
        n = plan.size();

        for (int c = 0; c < n; c++) begin
            MemReady = plan[c];
            Zero     = (cls == C_BEQ) ? zero_v : 1'($urandom);
            @(negedge clk);
            if (PCWrite)  pcw++;
            if (RegWrite) begin rw++; if (c == n - 1) rw_last++; end
            if (MemWrite) mw++;
            if (IRWrite)  begin irw++; irw_at = c; end
            if (InstrDone) begin done++; done_at = c; end
            if (IllegalOp) begin ill++; ill_at = c; end
            if (AdrSrc)   adr++;
            if (c == fs + 2) ula_exec = ULAControl;
            if (c == n - 1)  rsrc_last = ResultSrc;
            @(posedge clk);
            #1;
        end

        writer = (cls == C_R) || (cls == C_I) || (cls == C_LW) || (cls == C_JAL) || (cls == C_JALR);
        is_mem = (cls == C_LW) || (cls == C_SW);
        check_eq({name, ".pcwrite"}, pcw,
                 1 + ((cls == C_BEQ && zero_v) ? 1 : 0) + ((cls == C_JAL || cls == C_JALR) ? 1 : 0));
        check_eq({name, ".regwrite"}, rw, writer ? 1 : 0);
        check_eq({name, ".regwrite_last"}, rw_last, writer ? 1 : 0);
        check_eq({name, ".memwrite"}, mw, (cls == C_SW) ? ms + 1 : 0);
        check_eq({name, ".irwrite"}, irw, 1);
        check_eq({name, ".irwrite_at"}, irw_at, fs);
        check_eq({name, ".adrsrc"}, adr, is_mem ? ms + 1 : 0);
        if (cls == C_ILL) begin
            check_eq({name, ".done"}, done, 0);
            check_eq({name, ".illegal"}, ill, 1);
            check_eq({name, ".illegal_at"}, ill_at, fs + 1);
        end else begin
            check_eq({name, ".done"}, done, 1);
            check_eq({name, ".done_at"}, done_at, n - 1);
            check_eq({name, ".illegal"}, ill, 0);
            check_eq({name, ".ulactrl"}, ula_exec, exp_ula);
            retired_model++;
        end
        if (writer) check_eq({name, ".resultsrc"}, rsrc_last, (cls == C_LW) ? 2'b01 : 2'b00);
        check_eq({name, ".retired"}, Retired, retired_model);
        $display("[TB] %s cls=%0d var=%0d fs=%0d ms=%0d zero=%0d cycles=%0d retired=%0d",
                 name, cls, v, fs, ms, zero_v, n, Retired);
    endtask

    initial begin
        int cls, v;
        reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;
        OP = 7'b0110011; Funct3 = 3'b000; Funct7 = 7'h00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset.irwrite", IRWrite, 1'b0);
        check_eq("reset.pcwrite", PCWrite, 1'b0);
        check_eq("reset.retired", Retired, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(C_R,    0, 0, 0, 1'b0, "add");
        run_instr(C_LW,   0, 0, 2, 1'b0, "lw_stall2");
        run_instr(C_BEQ,  0, 0, 0, 1'b1, "beq_taken");
        run_instr(C_BEQ,  0, 0, 0, 1'b0, "beq_not_taken");
        run_instr(C_JALR, 0, 0, 0, 1'b0, "jalr");
        run_instr(C_ILL,  0, 0, 0, 1'b0, "illegal_ff");
        run_instr(C_SW,   0, 1, 1, 1'b0, "sw_stall");

        for (int k = 0; k < 60; k++) begin
            cls = $urandom_range(0, 7);
            v   = $urandom_range(0, 6);
            run_instr(cls, v, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), $sformatf("rnd%0d", k));
        end

        // Reset while a store waits on memory: no write, back to FETCH, counter cleared.
        OP = 7'b0100011; Funct3 = 3'b010;
        MemReady = 1'b1; @(posedge clk); #1;
        MemReady = 1'($urandom); @(posedge clk); #1;
        MemReady = 1'($urandom); @(posedge clk); #1;
        MemReady = 1'b0;
        @(negedge clk);
        check_eq("rst_mw.pre_memwrite", MemWrite, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mw.memwrite", MemWrite, 1'b0);
        check_eq("rst_mw.done", InstrDone, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        retired_model = '0;
        OP = 7'b1111111; MemReady = 1'b1;
        @(negedge clk);
        check_eq("rst_mw.fetch_irwrite", IRWrite, 1'b1);
        check_eq("rst_mw.retired", Retired, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_mw.illegal", IllegalOp, 1'b1);
        @(posedge clk); #1;
        $display("[TB] reset during MEMWRITE wait, retired=%0d", Retired);

        run_instr(C_R, 1, 0, 0, 1'b0, "post_reset_sub");
        run_instr(C_I, 0, 2, 0, 1'b0, "post_reset_addi");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
